decodificador_teclado: RTL and testbench

//   Inverse of the keypad priority encoder. Accepts a 4-bit key code over a valid/ready handshake.

---
 rtl/decodificador_teclado.sv | 125 ++++++++++++
 tb/tb_decodificador_teclado.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_teclado.sv
// Keypad replay decoder: turns a 4-bit key code into a timed one-hot keypad press followed by a release gap.
// Optional build macro DECOD_ERRO_EN adds the codigo_invalido one-cycle error pulse output.
module decodificador_teclado #(
  parameter int PRESS_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] BCD,
  input  logic       dado_valido,
  output logic       pronto,
  output logic [9:0] teclado,
  output logic       enablen,
  output logic       ocupado
`ifdef DECOD_ERRO_EN
  ,
  output logic       codigo_invalido
`endif
);

  localparam int CNT_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       key_q, key_d;
  logic [9:0]       decodedLine;
  logic             accept;

  // Invalid codes map to all-zero, which doubles as the validity test.
  always_comb begin
    decodedLine = 10'd0;
    case (BCD)
      4'd15:   decodedLine = 10'b10_0000_0000;
      4'd6:    decodedLine = 10'b01_0000_0000;
      4'd14:   decodedLine = 10'b00_1000_0000;
      4'd1:    decodedLine = 10'b00_0100_0000;
      4'd9:    decodedLine = 10'b00_0010_0000;
      4'd5:    decodedLine = 10'b00_0001_0000;
      4'd13:   decodedLine = 10'b00_0000_1000;
      4'd3:    decodedLine = 10'b00_0000_0100;
      4'd11:   decodedLine = 10'b00_0000_0010;
      4'd7:    decodedLine = 10'b00_0000_0001;
      default: decodedLine = 10'd0;
    endcase
  end

  assign accept = dado_valido && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (accept && (decodedLine != 10'd0)) begin
          state_d = PRESS;
          cnt_d   = '0;
          key_d   = decodedLine;
        end
      end
      PRESS: begin
        if (cnt_q == PRESS_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= 10'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
    end
  end

  // Outputs come straight from registered state so the keypad lines never glitch.
  assign teclado = (state_q == PRESS) ? key_q : 10'd0;
  assign enablen = (state_q != PRESS);
  assign pronto  = (state_q == IDLE);
  assign ocupado = (state_q != IDLE);

`ifdef DECOD_ERRO_EN
  logic erro_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= accept && (decodedLine == 10'd0);
    end
  end

  assign codigo_invalido = erro_q;
`endif

endmodule

// File: tb/tb_decodificador_teclado.sv
// Scoreboard bench for decodificador_teclado: a countdown model predicts handshake and keypad timing,
// and a monitor process compares every cycle and pops expected keys as presses appear.
module tb_decodificador_teclado;

  localparam int P = 4;
  localparam int G = 2;

  logic       clk;
  logic       reset_n;
  logic [3:0] BCD;
  logic       dado_valido;
  logic       pronto;
  logic [9:0] teclado;
  logic       enablen;
  logic       ocupado;
`ifdef DECOD_ERRO_EN
  logic       codigo_invalido;
  logic       expInv;
`endif

  decodificador_teclado #(
    .PRESS_CYCLES(P),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .BCD(BCD),
    .dado_valido(dado_valido),
    .pronto(pronto),
    .teclado(teclado),
    .enablen(enablen),
    .ocupado(ocupado)
`ifdef DECOD_ERRO_EN
    ,
    .codigo_invalido(codigo_invalido)
`endif
  );

  int checks = 0;
  int failures = 0;
  int remain = 0;
  logic [9:0] curKey = 10'd0;
  logic [9:0] expQ[$];
  logic monitorOn = 1'b0;
  int keyTable[10] = '{7, 11, 3, 13, 5, 9, 1, 14, 6, 15};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] expectedLine(input logic [3:0] code);
    logic [9:0] line;
    line = 10'd0;
    for (int i = 0; i < 10; i++)
      if (keyTable[i] == int'(code)) line = 10'd1 << i;
    return line;
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of stimulus, then advance the reference model across the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] code, output logic acc);
    logic [9:0] line;
    @(negedge clk);
    dado_valido = v;
    BCD = code;
    @(posedge clk);
    acc = v && (remain == 0) && reset_n;
    line = expectedLine(code);
`ifdef DECOD_ERRO_EN
    expInv = acc && (line == 10'd0);
`endif
    if (acc) begin
      if (line != 10'd0) begin
        remain = P + G;
        curKey = line;
        expQ.push_back(line);
      end
    end else if (remain > 0) begin
      remain--;
    end
  endtask

  initial begin : monitor
    logic [9:0] prevTec;
    logic [9:0] expTec;
    logic [9:0] got;
    prevTec = 10'd0;
    forever begin
      @(negedge clk);
      if (monitorOn) begin
        expTec = (remain > G) ? curKey : 10'd0;
        checkOutput("teclado", 32'(teclado), 32'(expTec));
        checkOutput("enablen", 32'(enablen), 32'(expTec == 10'd0));
        checkOutput("pronto", 32'(pronto), 32'(remain == 0));
        checkOutput("ocupado", 32'(ocupado), 32'(remain != 0));
        checkOutput("oneHot", 32'($countones(teclado) <= 1), 32'd1);
`ifdef DECOD_ERRO_EN
        checkOutput("codigo_invalido", 32'(codigo_invalido), 32'(expInv));
`endif
        if (teclado != 10'd0 && prevTec == 10'd0) begin
          if (expQ.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd1, 32'd0);
          end else begin
            got = expQ.pop_front();
            checkOutput("scoreboardKey", 32'(teclado), 32'(got));
          end
        end
        prevTec = teclado;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic acc;
    int tries;
    reset_n = 1'b0;
    dado_valido = 1'b0;
    BCD = 4'd0;
`ifdef DECOD_ERRO_EN
    expInv = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("resetTeclado", 32'(teclado), 32'd0);
    checkOutput("resetEnablen", 32'(enablen), 32'd1);
    checkOutput("resetPronto", 32'(pronto), 32'd1);
    checkOutput("resetOcupado", 32'(ocupado), 32'd0);
    #1 reset_n = 1'b1;
    monitorOn = 1'b1;

    // Single press of the highest key, then idle long enough to see the full gap.
    applyStimulus(1'b1, 4'd15, acc);
    repeat (8) applyStimulus(1'b0, 4'd15, acc);

    // Back-to-back sweep with valid held high.
    for (int i = 0; i < 10; i++) begin
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        applyStimulus(1'b1, 4'(keyTable[i]), acc);
        tries++;
      end
    end
    repeat (8) applyStimulus(1'b0, 4'd0, acc);

    // Invalid code is consumed without a press.
    applyStimulus(1'b1, 4'd4, acc);
    repeat (3) applyStimulus(1'b0, 4'd4, acc);

    // New request during a press must wait for the gap to finish.
    applyStimulus(1'b1, 4'd7, acc);
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      applyStimulus(1'b1, 4'd1, acc);
      tries++;
    end
    repeat (8) applyStimulus(1'b0, 4'd1, acc);

    // Asynchronous reset in the second press cycle drops the pending key.
    applyStimulus(1'b1, 4'd9, acc);
    applyStimulus(1'b0, 4'd9, acc);
    #2 reset_n = 1'b0;
    remain = 0;
    curKey = 10'd0;
`ifdef DECOD_ERRO_EN
    expInv = 1'b0;
`endif
    #1;
    checkOutput("asyncResetTeclado", 32'(teclado), 32'd0);
    checkOutput("asyncResetPronto", 32'(pronto), 32'd1);
    checkOutput("asyncResetEnablen", 32'(enablen), 32'd1);
    checkOutput("asyncResetOcupado", 32'(ocupado), 32'd0);
    repeat (2) applyStimulus(1'b0, 4'd9, acc);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (8) applyStimulus(1'b0, 4'd9, acc);

    // Randomised traffic, including codes changing while busy.
    for (int n = 0; n < 300; n++)
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), acc);
    repeat (10) applyStimulus(1'b0, 4'd0, acc);

    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
